snoopy_sprite_drawer: RTL and testbench
=======================================

# snoopy_sprite_drawer

Consumer of the vertical-position output of Snoopy's jump FSM. On each frame tick it erases the sprite at the previously drawn row and redraws it at the current `snoopy_y`, emitting one pixel per cycle to the VGA adapter's plot interface. Sprite pixels are fetched row by row from an external 1-cycle-latency sprite ROM. It sits between the vertical FSM and the VGA adapter in the game top level.

## Interface
- `SPRITE_W`, 8: sprite width in pixels; also the ROM data width.
- `SPRITE_H`, 8: sprite height in rows.
- `SNOOPY_X`, 20: fixed screen column of the sprite's left edge.
- `SCREEN_H`, 120: visible rows; valid y is 0..SCREEN_H-1.
- `COLOUR_FG`, 3'b111: colour for set sprite bits.
- `COLOUR_BG`, 3'b000: erase colour.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle redraw request.
- `snoopy_y`  in  7  current sprite top row, from the vertical FSM.
- `rom_addr`  out  $clog2(SPRITE_H)  sprite row address.
- `rom_data`  in  SPRITE_W  row bitmap, valid 1 cycle after `rom_addr`. Bit 0 is the leftmost pixel.
- `vga_x`  out  8  pixel column.
- `vga_y`  out  7  pixel row.
- `vga_colour`  out  3  pixel colour.
- `plot`  out  1  pixel-write strobe.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse at the end of a redraw.

## Operation
- **States:** IDLE, ERASE, FETCH, DRAW, DONE.
- **IDLE**
  - On `frame_tick`, latch `new_y <= snoopy_y`.
  - If `drawn_valid` is set and `new_y == drawn_y`, go to DONE (no pixels are plotted).
  - Otherwise, if `drawn_valid` is set, go to ERASE with `row = col = 0`.
  - Otherwise (no sprite drawn yet), go to FETCH.
  - A `frame_tick` while busy is ignored; requests are not queued.
- **ERASE:** one pixel per cycle at (SNOOPY_X+col, drawn_y+row) in COLOUR_BG.
  - Scan order is col fastest, then row.
  - After (W-1, H-1), reset the counters and go to FETCH.
- **FETCH:** drive `rom_addr = row` for 1 cycle, then go to DRAW.
- **DRAW:** for col = 0..W-1, compute pixel (SNOOPY_X+col, new_y+row).
  - `plot = rom_data[col]`; clear bits are transparent but still consume a cycle.
  - At col = W-1: if row < H-1, increment row and go to FETCH; otherwise go to DONE.
- **DONE:**
  - Set `drawn_y <= new_y` and `drawn_valid <= 1`.
  - Pulse `done` for exactly 1 cycle, then return to IDLE.
- **Address width:** the y sum `base+row` is computed at 8 bits.
- **Clipping:** any pixel with `base+row >= SCREEN_H` is suppressed (`plot = 0`), but its cycle is still consumed.
- **rom_data sampling:** `rom_data` is captured into a row register on the first DRAW cycle of each row.

## Timing
- **Registered outputs:** `vga_x`, `vga_y`, `vga_colour` and `plot` are registered. Each reflects the pixel computed in the previous state cycle, so the final DRAW pixel appears in the DONE cycle.
- **Cycle budget** (defaults): tick accepted at edge N.
  - ERASE covers cycles N+1..N+64.
  - Each row then takes 1 FETCH + 8 DRAW cycles, 72 cycles in total.
  - DONE falls in cycle N+137; `done` is high for that cycle only.
  - The first redraw after reset has no ERASE, so DONE falls in cycle N+73.
- **Skip path:** DONE falls in cycle N+1, with zero plots.
- **`busy`:** high from cycle N+1 through the DONE cycle inclusive; low in IDLE.
- **Reset** (asynchronous, any time, including mid-draw):
  - State returns to IDLE; `drawn_valid = 0`, `drawn_y = 0`, `new_y = 0`, row and col counters = 0.
  - All outputs go to 0.
  - A partially drawn sprite is left on screen and is not erased.
- **`snoopy_y`:** sampled only in the accepting cycle; changes during a redraw have no effect until the next tick.

## Test plan
- **First draw:** reset; `snoopy_y=100`; ROM row r = 8'hFF.
  - Tick → exactly 64 plots, all COLOUR_FG, x=20..27, y=100..107.
  - No BG plots; `done` falls 73 cycles after the tick.
- **Move:** after the first draw, `snoopy_y=90`, tick.
  - 64 BG plots at y=100..107, then FG plots at y=90..97.
  - `done` falls 137 cycles after the tick.
- **Unchanged y:** tick again with `snoopy_y=90` → 0 plots; `done` pulses the cycle after the tick; `busy` is high for 1 cycle.
- **Transparency and clipping:** ROM = 8'b0000_0101 on all rows; `snoopy_y=116` on first draw.
  - Plots only at x=20,22 for y=116..119, i.e. 8 plots.
  - Rows 120..123 are suppressed; cycle count is unchanged (73).
- **Busy tick and mid-draw reset:**
  - A tick during ERASE is ignored: one `done` only.
  - Asserting `reset` mid-DRAW forces outputs to 0 immediately.
  - The next tick performs a first-draw, with no ERASE.

Source files
------------

// File: rtl/snoopy_sprite_drawer_if.sv
// Bundle of the drawer's frame request, sprite ROM and VGA plot signals.
// The master modport is the drawer; the slave modport is its surroundings
// (vertical FSM, sprite ROM and VGA adapter).
interface snoopy_sprite_drawer_if #(
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned ADDR_W   = 3
);
    logic                frame_tick;
    logic [6:0]          snoopy_y;
    logic [ADDR_W-1:0]   rom_addr;
    logic [SPRITE_W-1:0] rom_data;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [2:0]          vga_colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        input  frame_tick, snoopy_y, rom_data,
        output rom_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        output frame_tick, snoopy_y, rom_data,
        input  rom_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/snoopy_sprite_drawer.sv
// Erases Snoopy at the previously drawn row and redraws him at the current
// row on each frame tick, one pixel per cycle, fetching sprite rows from a
// 1-cycle-latency ROM. Pixel outputs are registered, so each lags the state
// that computed it by one cycle.
module snoopy_sprite_drawer #(
    parameter int unsigned SPRITE_W  = 8,
    parameter int unsigned SPRITE_H  = 8,
    parameter int unsigned SNOOPY_X  = 20,
    parameter int unsigned SCREEN_H  = 120,
    parameter logic [2:0]  COLOUR_FG = 3'b111,
    parameter logic [2:0]  COLOUR_BG = 3'b000
) (
    input logic                     clock,
    input logic                     reset,
    snoopy_sprite_drawer_if.master  bus
);
    localparam int unsigned ColW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned RowW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(SPRITE_W - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(SPRITE_H - 1);

    typedef enum logic [2:0] {StIdle, StErase, StFetch, StDraw, StDone} state_e;

    state_e              state_q;
    logic [6:0]          new_y_q;
    logic [6:0]          drawn_y_q;
    logic                drawn_valid_q;
    logic [RowW-1:0]     row_q;
    logic [ColW-1:0]     col_q;
    logic [SPRITE_W-1:0] row_bits_q;
    logic [7:0]          vga_x_q;
    logic [6:0]          vga_y_q;
    logic [2:0]          colour_q;
    logic                plot_q;
    logic                busy_q;
    logic                done_q;

    logic [6:0]          base_y;
    logic [7:0]          y_sum;
    logic                y_clip;
    logic [7:0]          pix_x;
    logic [SPRITE_W-1:0] draw_bits;

    // Pixel address of the current scan position; the y sum is 8 bits wide
    // so rows running past the bottom of the screen clip instead of wrapping.
    always_comb begin
        base_y    = (state_q == StErase) ? drawn_y_q : new_y_q;
        y_sum     = {1'b0, base_y} + 8'(row_q);
        y_clip    = (y_sum >= 8'(SCREEN_H));
        pix_x     = 8'(SNOOPY_X) + 8'(col_q);
        // ROM data is only valid on the first DRAW cycle of a row.
        draw_bits = (col_q == '0) ? bus.rom_data : row_bits_q;
    end

    // Redraw FSM with registered pixel, busy and done outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            new_y_q       <= '0;
            drawn_y_q     <= '0;
            drawn_valid_q <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            row_bits_q    <= '0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.frame_tick) begin
                        new_y_q <= bus.snoopy_y;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        if (drawn_valid_q && (bus.snoopy_y == drawn_y_q)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (drawn_valid_q) begin
                            state_q <= StErase;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StErase: begin
                    vga_x_q  <= pix_x;
                    vga_y_q  <= y_sum[6:0];
                    colour_q <= COLOUR_BG;
                    plot_q   <= !y_clip;
                    if (col_q == ColLast) begin
                        col_q <= '0;
                        if (row_q == RowLast) begin
                            row_q   <= '0;
                            state_q <= StFetch;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StDraw;
                end
                StDraw: begin
                    if (col_q == '0) begin
                        row_bits_q <= bus.rom_data;
                    end
                    vga_x_q  <= pix_x;
                    vga_y_q  <= y_sum[6:0];
                    colour_q <= COLOUR_FG;
                    // Clear bits are transparent but still take their cycle.
                    plot_q   <= draw_bits[col_q] && !y_clip;
                    if (col_q == ColLast) begin
                        col_q <= '0;
                        if (row_q == RowLast) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            row_q   <= row_q + 1'b1;
                            state_q <= StFetch;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                StDone: begin
                    drawn_y_q     <= new_y_q;
                    drawn_valid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rom_addr   = row_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
// Bench for snoopy_sprite_drawer: a per-cycle behavioural model predicts every
// output from the redraw rules, directed scenarios pin plot counts and
// latencies, and a randomized phase throws ticks, rows and bitmaps at it.
module tb_snoopy_sprite_drawer;
    localparam int W        = 8;
    localparam int H        = 8;
    localparam int X0       = 20;
    localparam int SCREEN_H = 120;
    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    snoopy_sprite_drawer_if #(.SPRITE_W(W), .ADDR_W(3)) bus ();

    snoopy_sprite_drawer #(
        .SPRITE_W (W),
        .SPRITE_H (H),
        .SNOOPY_X (X0),
        .SCREEN_H (SCREEN_H),
        .COLOUR_FG(FG),
        .COLOUR_BG(BG)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Sprite ROM with one cycle of read latency.
    logic [7:0] rom_rows [H];
    always @(posedge clock) bus.rom_data <= rom_rows[bus.rom_addr];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;
    bit   m_valid = 1'b0;
    int   m_y = 0;
    int   m_last_len = 0;
    int   m_last_plots = 0;

    // Expected output stream for one accepted tick: first cycle shows no pixel,
    // then each work cycle's pixel one cycle later, done on the last entry.
    task automatic build(input int ny);
        exp_t pix[$];
        exp_t e;
        int   n;
        if (!(m_valid && ny == m_y)) begin
            if (m_valid) begin
                for (int r = 0; r < H; r++) begin
                    for (int c = 0; c < W; c++) begin
                        e = '0;
                        e.plot = (m_y + r < SCREEN_H);
                        e.x = 8'(X0 + c);
                        e.y = 7'(m_y + r);
                        e.c = BG;
                        pix.push_back(e);
                    end
                end
            end
            for (int r = 0; r < H; r++) begin
                e = '0;
                pix.push_back(e);
                for (int c = 0; c < W; c++) begin
                    e = '0;
                    e.plot = rom_rows[r][c] && (ny + r < SCREEN_H);
                    e.x = 8'(X0 + c);
                    e.y = 7'(ny + r);
                    e.c = FG;
                    pix.push_back(e);
                end
            end
        end
        e = '0;
        pix.push_front(e);
        n = 0;
        for (int k = 0; k < pix.size(); k++) begin
            e = pix[k];
            e.busy = 1'b1;
            e.done = (k == pix.size() - 1);
            if (e.plot) n++;
            exp_q.push_back(e);
        end
        m_last_len = pix.size();
        m_last_plots = n;
        m_valid = 1'b1;
        m_y = ny;
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                exp_q.delete();
                cur = '0;
                m_valid = 1'b0;
                m_y = 0;
            end else begin
                if (!cur.busy && bus.frame_tick) build(int'(bus.snoopy_y));
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else cur = '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                vectors++;
                if (bus.plot !== cur.plot || bus.busy !== cur.busy || bus.done !== cur.done ||
                    (cur.plot && (bus.vga_x !== cur.x || bus.vga_y !== cur.y ||
                                  bus.vga_colour !== cur.c))) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: got plot=%b x=%0d y=%0d c=%0d busy=%b done=%b, expected plot=%b x=%0d y=%0d c=%0d busy=%b done=%b",
                             $time, bus.plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.busy,
                             bus.done, cur.plot, cur.x, cur.y, cur.c, cur.busy, cur.done);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    int fg_minx, fg_maxx, fg_miny, fg_maxy, bg_miny, bg_maxy;

    task automatic do_redraw(input logic [6:0] y, input int extra, output int lat,
                             output int nfg, output int nbg, output int busy_cyc);
        lat = -1; nfg = 0; nbg = 0; busy_cyc = 0;
        fg_minx = 999; fg_maxx = -1; fg_miny = 999; fg_maxy = -1;
        bg_miny = 999; bg_maxy = -1;
        @(posedge clock); #1;
        bus.frame_tick = 1'b1;
        bus.snoopy_y = y;
        @(posedge clock); #1;
        bus.frame_tick = 1'b0;
        bus.snoopy_y = 7'($urandom);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            bus.frame_tick = (k == extra);
            if (k == extra) bus.snoopy_y = 7'($urandom);
            if (bus.busy) busy_cyc++;
            if (bus.plot) begin
                if (bus.vga_colour == FG) begin
                    nfg++;
                    if (int'(bus.vga_x) < fg_minx) fg_minx = int'(bus.vga_x);
                    if (int'(bus.vga_x) > fg_maxx) fg_maxx = int'(bus.vga_x);
                    if (int'(bus.vga_y) < fg_miny) fg_miny = int'(bus.vga_y);
                    if (int'(bus.vga_y) > fg_maxy) fg_maxy = int'(bus.vga_y);
                end else begin
                    nbg++;
                    if (int'(bus.vga_y) < bg_miny) bg_miny = int'(bus.vga_y);
                    if (int'(bus.vga_y) > bg_maxy) bg_maxy = int'(bus.vga_y);
                end
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.frame_tick = 1'b0;
        if (lat < 0) $display("FAIL redraw timeout: no done within 300 cycles");
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (bus.done) cnt++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int lat, nfg, nbg, bcyc, nd, len;
    logic [6:0] ry;

    initial begin
        bus.frame_tick = 1'b0;
        bus.snoopy_y = '0;
        for (int r = 0; r < H; r++) rom_rows[r] = 8'hFF;
        #2 reset = 1'b1;
        #1;
        check("reset outputs", {bus.plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.busy,
                                bus.done}, 0);
        chk_en = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // First draw at row 100, solid sprite.
        do_redraw(7'd100, 0, lat, nfg, nbg, bcyc);
        check("model first len", m_last_len, 73);
        check("model first plots", m_last_plots, 64);
        check("first latency", lat, 73);
        check("first fg plots", nfg, 64);
        check("first bg plots", nbg, 0);
        check("first x min", fg_minx, 20);
        check("first x max", fg_maxx, 27);
        check("first y min", fg_miny, 100);
        check("first y max", fg_maxy, 107);

        // Move to row 90.
        do_redraw(7'd90, 0, lat, nfg, nbg, bcyc);
        check("model move len", m_last_len, 137);
        check("move latency", lat, 137);
        check("move bg plots", nbg, 64);
        check("move fg plots", nfg, 64);
        check("move bg y min", bg_miny, 100);
        check("move bg y max", bg_maxy, 107);
        check("move fg y min", fg_miny, 90);
        check("move fg y max", fg_maxy, 97);

        // Same row: skip path.
        do_redraw(7'd90, 0, lat, nfg, nbg, bcyc);
        check("model skip len", m_last_len, 1);
        check("skip latency", lat, 1);
        check("skip plots", nfg + nbg, 0);
        check("skip busy cycles", bcyc, 1);
        @(negedge clock);
        check("skip busy after", bus.busy, 0);

        // Transparency and clipping on a fresh first draw.
        pulse_reset();
        for (int r = 0; r < H; r++) rom_rows[r] = 8'b0000_0101;
        do_redraw(7'd116, 0, lat, nfg, nbg, bcyc);
        check("model clip plots", m_last_plots, 8);
        check("clip latency", lat, 73);
        check("clip fg plots", nfg, 8);
        check("clip x min", fg_minx, 20);
        check("clip x max", fg_maxx, 22);
        check("clip y min", fg_miny, 116);
        check("clip y max", fg_maxy, 119);

        // A tick during ERASE is ignored.
        do_redraw(7'd50, 10, lat, nfg, nbg, bcyc);
        check("busy tick latency", lat, 137);
        check("busy tick bg plots", nbg, 32);
        check("busy tick fg plots", nfg, 16);
        count_done(200, nd);
        check("busy tick extra done", nd, 0);

        // Reset mid-DRAW, then the next redraw is a first draw.
        @(posedge clock); #1;
        bus.frame_tick = 1'b1;
        bus.snoopy_y = 7'd10;
        @(posedge clock); #1;
        bus.frame_tick = 1'b0;
        repeat (80) @(negedge clock);
        check("mid-draw busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid-draw reset x", bus.vga_x, 0);
        check("mid-draw reset outputs", {bus.plot, bus.vga_x, bus.vga_y, bus.vga_colour,
                                         bus.busy, bus.done}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int r = 0; r < H; r++) rom_rows[r] = 8'hFF;
        do_redraw(7'd30, 0, lat, nfg, nbg, bcyc);
        check("post-reset latency", lat, 73);
        check("post-reset bg plots", nbg, 0);
        check("post-reset fg plots", nfg, 64);

        // Randomized ticks, rows and bitmaps, checked cycle by cycle.
        ry = 7'd0;
        for (int chunk = 0; chunk < 25; chunk++) begin
            for (int r = 0; r < H; r++) rom_rows[r] = 8'($urandom);
            len = $urandom_range(100, 300);
            for (int c = 0; c < len; c++) begin
                @(posedge clock); #1;
                bus.frame_tick = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) != 0) ry = 7'($urandom_range(0, 127));
                bus.snoopy_y = ry;
            end
            @(posedge clock); #1;
            bus.frame_tick = 1'b0;
            nd = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clock);
                if (!bus.busy) begin
                    nd = 1;
                    break;
                end
            end
            check("random drain idle", nd, 1);
        end

        repeat (3) @(negedge clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
